// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request fields and datapath control strobes of the ALU op sequencer
interface alu_op_sequencer_if;
  logic        start;
  logic [4:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        Yin;
  logic        Yout;
  logic        Zin;
  logic        ZLOin;
  logic        ZHIin;
  logic        ZLowSelect;
  logic        ZHighSelect;
  logic        ZLOout;
  logic        ZHIout;
  logic        HIin;
  logic        Loin;
  logic [4:0]  ALU_opcode;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, op, ra, rb, rc,
    input  Rin, Rout, Yin, Yout, Zin, ZLOin, ZHIin, ZLowSelect, ZHighSelect,
    input  ZLOout, ZHIout, HIin, Loin, ALU_opcode, busy, done, err
  );

  modport slave (
    input  start, op, ra, rb, rc,
    output Rin, Rout, Yin, Yout, Zin, ZLOin, ZHIin, ZLowSelect, ZHighSelect,
    output ZLOout, ZHIout, HIin, Loin, ALU_opcode, busy, done, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences one register ALU operation through LDY/EXEC/WBLO/WBHI
module alu_op_sequencer (
  input logic               clk,
  input logic               clr,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LDY, EXEC, WBLO, WBHI} state_t;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        yin;
    logic        yout;
    logic        zin;
    logic        zloin;
    logic        zhiin;
    logic        zlowsel;
    logic        zhighsel;
    logic        zloout;
    logic        zhiout;
    logic        hiin;
    logic        loin;
    logic [4:0]  alu_opcode;
    logic        busy;
    logic        done;
  } ctl_t;

  state_t     state;
  ctl_t       ctl;
  logic       err_q;
  logic [4:0] op_q;
  logic [3:0] ra_q;
  logic [3:0] rb_q;
  logic [3:0] rc_q;

  function automatic logic is_unary(input logic [4:0] o);
    return (o == 5'b10000) || (o == 5'b10001);
  endfunction

  function automatic logic is_wide(input logic [4:0] o);
    return (o == 5'b01110) || (o == 5'b01111);
  endfunction

  function automatic logic is_legal(input logic [4:0] o);
    return o <= 5'b10001;
  endfunction

  // Strobes for the state being entered, so every output comes straight from a flop.
  function automatic ctl_t decode(input state_t s, input logic [4:0] o,
                                  input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] c);
    ctl_t d;
    d = '0;
    case (s)
      LDY: begin
        d.rout = 16'h0001 << b;
        d.yin  = 1'b1;
        d.busy = 1'b1;
      end
      EXEC: begin
        d.alu_opcode = o;
        d.zin        = 1'b1;
        d.zloin      = 1'b1;
        d.busy       = 1'b1;
        if (is_unary(o)) begin
          d.yout = 1'b1;
        end else begin
          d.rout  = 16'h0001 << c;
          d.zhiin = 1'b1;
        end
      end
      WBLO: begin
        d.zlowsel = 1'b1;
        d.zloout  = 1'b1;
        d.busy    = 1'b1;
        if (is_wide(o)) begin
          d.loin = 1'b1;
        end else begin
          d.rin  = 16'h0001 << a;
          d.done = 1'b1;
        end
      end
      WBHI: begin
        d.zhighsel = 1'b1;
        d.zhiout   = 1'b1;
        d.hiin     = 1'b1;
        d.done     = 1'b1;
        d.busy     = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      ctl   <= '0;
      err_q <= 1'b0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_legal(bus.op)) begin
              state <= LDY;
              op_q  <= bus.op;
              ra_q  <= bus.ra;
              rb_q  <= bus.rb;
              rc_q  <= bus.rc;
              ctl   <= decode(LDY, bus.op, bus.ra, bus.rb, bus.rc);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LDY: begin
          state <= EXEC;
          ctl   <= decode(EXEC, op_q, ra_q, rb_q, rc_q);
        end
        EXEC: begin
          state <= WBLO;
          ctl   <= decode(WBLO, op_q, ra_q, rb_q, rc_q);
        end
        WBLO: begin
          if (is_wide(op_q)) begin
            state <= WBHI;
            ctl   <= decode(WBHI, op_q, ra_q, rb_q, rc_q);
          end else begin
            state <= IDLE;
            ctl   <= '0;
          end
        end
        WBHI: begin
          state <= IDLE;
          ctl   <= '0;
        end
        default: begin
          state <= IDLE;
          ctl   <= '0;
        end
      endcase
    end
  end

  assign bus.Rin         = ctl.rin;
  assign bus.Rout        = ctl.rout;
  assign bus.Yin         = ctl.yin;
  assign bus.Yout        = ctl.yout;
  assign bus.Zin         = ctl.zin;
  assign bus.ZLOin       = ctl.zloin;
  assign bus.ZHIin       = ctl.zhiin;
  assign bus.ZLowSelect  = ctl.zlowsel;
  assign bus.ZHighSelect = ctl.zhighsel;
  assign bus.ZLOout      = ctl.zloout;
  assign bus.ZHIout      = ctl.zhiout;
  assign bus.HIin        = ctl.hiin;
  assign bus.Loin        = ctl.loin;
  assign bus.ALU_opcode  = ctl.alu_opcode;
  assign bus.busy        = ctl.busy;
  assign bus.done        = ctl.done;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with directed vectors
module tb_alu_op_sequencer;
  logic clk;
  logic clr;
  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (.clk(clk), .clr(clr), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: Rin, Rout, 11 strobes, ALU_opcode, busy, done, err
  localparam logic [10:0] S_YIN  = 11'b100_0000_0000;
  localparam logic [10:0] S_YOUT = 11'b010_0000_0000;
  localparam logic [10:0] S_ZIN  = 11'b001_0000_0000;
  localparam logic [10:0] S_ZLOI = 11'b000_1000_0000;
  localparam logic [10:0] S_ZHII = 11'b000_0100_0000;
  localparam logic [10:0] S_ZLS  = 11'b000_0010_0000;
  localparam logic [10:0] S_ZHS  = 11'b000_0001_0000;
  localparam logic [10:0] S_ZLOO = 11'b000_0000_1000;
  localparam logic [10:0] S_ZHIO = 11'b000_0000_0100;
  localparam logic [10:0] S_HIIN = 11'b000_0000_0010;
  localparam logic [10:0] S_LOIN = 11'b000_0000_0001;

  logic [50:0] sb[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  function automatic logic [50:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic [10:0] s, input logic [4:0] opc,
                                     input logic busy, input logic done, input logic err);
    return {rin, rout, s, opc, busy, done, err};
  endfunction

  function automatic logic [50:0] actual();
    return {bus.Rin, bus.Rout, bus.Yin, bus.Yout, bus.Zin, bus.ZLOin, bus.ZHIin,
            bus.ZLowSelect, bus.ZHighSelect, bus.ZLOout, bus.ZHIout, bus.HIin, bus.Loin,
            bus.ALU_opcode, bus.busy, bus.done, bus.err};
  endfunction

  // Monitor: every active cycle must match the next scoreboard entry; idle cycles must be all zero.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [50:0] a;
      logic [50:0] e;
      a = actual();
      checks = checks + 1;
      if (bus.busy || bus.err) begin
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_output actual=%h required=none", a);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            errors = errors + 1;
            $display("FAIL sequence_step actual=%h required=%h", a, e);
          end
        end
      end else if (a !== 51'h0) begin
        errors = errors + 1;
        $display("FAIL idle_outputs actual=%h required=0", a);
      end
    end
  end

  task automatic issue(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input int ncyc);
    bus.start = 1'b1;
    bus.op = o;
    bus.ra = a;
    bus.rb = b;
    bus.rc = c;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [50:0] req);
    logic [50:0] a;
    a = actual();
    checks = checks + 1;
    if (a !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, a, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.ra = '0;
    bus.rb = '0;
    bus.rc = '0;
    clr = 1'b1;
    #3 clr = 1'b0;
    #1 check_now("reset_state", 51'h0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Binary SUB-style op 00011: ra=2 rb=0 rc=1
    sb.push_back(mk(16'h0000, 16'h0001, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0002, S_ZIN | S_ZLOI | S_ZHII, 5'b00011, 1, 0, 0));
    sb.push_back(mk(16'h0004, 16'h0000, S_ZLS | S_ZLOO, 5'b00000, 1, 1, 0));
    issue(5'b00011, 4'd2, 4'd0, 4'd1, 3);

    // Unary NOT back-to-back: ra=0 rb=1, rc ignored
    sb.push_back(mk(16'h0000, 16'h0002, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0000, S_YOUT | S_ZIN | S_ZLOI, 5'b10001, 1, 0, 0));
    sb.push_back(mk(16'h0001, 16'h0000, S_ZLS | S_ZLOO, 5'b00000, 1, 1, 0));
    issue(5'b10001, 4'd0, 4'd1, 4'd7, 3);

    // Wide MUL: ra=5 rb=3 rc=4
    sb.push_back(mk(16'h0000, 16'h0008, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0010, S_ZIN | S_ZLOI | S_ZHII, 5'b01110, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0000, S_ZLS | S_ZLOO | S_LOIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0000, S_ZHS | S_ZHIO | S_HIIN, 5'b00000, 1, 1, 0));
    issue(5'b01110, 4'd5, 4'd3, 4'd4, 4);

    // Illegal ops: first illegal code, a middle one and the top code
    sb.push_back(mk(16'h0000, 16'h0000, 11'h0, 5'b00000, 0, 0, 1));
    issue(5'b10101, 4'd1, 4'd2, 4'd3, 1);
    sb.push_back(mk(16'h0000, 16'h0000, 11'h0, 5'b00000, 0, 0, 1));
    issue(5'b10010, 4'd1, 4'd2, 4'd3, 1);
    sb.push_back(mk(16'h0000, 16'h0000, 11'h0, 5'b00000, 0, 0, 1));
    issue(5'b11111, 4'd1, 4'd2, 4'd3, 1);

    // Highest binary code with top register indices
    sb.push_back(mk(16'h0000, 16'h4000, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h2000, S_ZIN | S_ZLOI | S_ZHII, 5'b01101, 1, 0, 0));
    sb.push_back(mk(16'h8000, 16'h0000, S_ZLS | S_ZLOO, 5'b00000, 1, 1, 0));
    issue(5'b01101, 4'd15, 4'd14, 4'd13, 3);

    // NEG: ra=7 rb=9
    sb.push_back(mk(16'h0000, 16'h0200, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0000, S_YOUT | S_ZIN | S_ZLOI, 5'b10000, 1, 0, 0));
    sb.push_back(mk(16'h0080, 16'h0000, S_ZLS | S_ZLOO, 5'b00000, 1, 1, 0));
    issue(5'b10000, 4'd7, 4'd9, 4'd2, 3);

    // DIV: ra=1 rb=15 rc=0
    sb.push_back(mk(16'h0000, 16'h8000, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0001, S_ZIN | S_ZLOI | S_ZHII, 5'b01111, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0000, S_ZLS | S_ZLOO | S_LOIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0000, S_ZHS | S_ZHIO | S_HIIN, 5'b00000, 1, 1, 0));
    issue(5'b01111, 4'd1, 4'd15, 4'd0, 4);

    // Same register as destination and both sources
    sb.push_back(mk(16'h0000, 16'h0008, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0008, S_ZIN | S_ZLOI | S_ZHII, 5'b00001, 1, 0, 0));
    sb.push_back(mk(16'h0008, 16'h0000, S_ZLS | S_ZLOO, 5'b00000, 1, 1, 0));
    issue(5'b00001, 4'd3, 4'd3, 4'd3, 3);

    // Start re-pulsed during EXEC with different fields must be ignored
    sb.push_back(mk(16'h0000, 16'h0040, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0020, S_ZIN | S_ZLOI | S_ZHII, 5'b00100, 1, 0, 0));
    sb.push_back(mk(16'h0200, 16'h0000, S_ZLS | S_ZLOO, 5'b00000, 1, 1, 0));
    issue(5'b00100, 4'd9, 4'd6, 4'd5, 1);
    bus.start = 1'b1;
    bus.op = 5'b01110;
    bus.ra = 4'd12;
    bus.rb = 4'd11;
    bus.rc = 4'd10;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted during EXEC aborts the operation
    sb.push_back(mk(16'h0000, 16'h0004, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0008, S_ZIN | S_ZLOI | S_ZHII, 5'b00010, 1, 0, 0));
    issue(5'b00010, 4'd4, 4'd2, 4'd3, 1);
    @(negedge clk);
    #2 clr = 1'b0;
    #1 check_now("abort_outputs", 51'h0);
    @(posedge clk);
    #1 clr = 1'b1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL abort_queue actual=%0d required=0", sb.size());
      sb.delete();
    end

    // First start after reset release runs normally
    sb.push_back(mk(16'h0000, 16'h0001, S_YIN, 5'b00000, 1, 0, 0));
    sb.push_back(mk(16'h0000, 16'h0002, S_ZIN | S_ZLOI | S_ZHII, 5'b00011, 1, 0, 0));
    sb.push_back(mk(16'h0004, 16'h0000, S_ZLS | S_ZLOO, 5'b00000, 1, 1, 0));
    issue(5'b00011, 4'd2, 4'd0, 4'd1, 3);

    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL final_queue actual=%0d required=0", sb.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
